weight_pad_reader: RTL

//  Read side of the PE weight scratch pad. Once load_weight starts filling the pad, this block

---
 rtl/weight_pad_reader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/weight_pad_reader.sv
// rtl/weight_pad_reader.sv - weight scratch-pad read side: gated address issue, 2-entry skid, valid/ready out
module weight_pad_reader #(
  parameter int DATA_WIDTH         = 16,
  parameter int ADDRESSWIDTH_W_PAD = 8,
  parameter int ADDRESSWIDTH_F_PAD = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          read_start_i,
  input  logic [ADDRESSWIDTH_W_PAD-1:0] weight_num_i,
  input  logic [ADDRESSWIDTH_F_PAD-1:0] pixel_num_i,
  input  logic [ADDRESSWIDTH_W_PAD-1:0] wr_addr_i,
  input  logic                          load_done_i,
  output logic [ADDRESSWIDTH_W_PAD-1:0] raddra_filter_o,
  input  logic [DATA_WIDTH-1:0]         weight_rd_data_i,
  output logic [ADDRESSWIDTH_W_PAD-1:0] base_address_o,
  output logic [DATA_WIDTH-1:0]         weight_out_o,
  output logic                          weight_out_valid_o,
  input  logic                          weight_out_ready_i,
  output logic                          pixel_done_o,
  output logic                          read_finish_o,
  output logic                          read_busy_o
);

  localparam int AW = ADDRESSWIDTH_W_PAD;
  localparam int FW = ADDRESSWIDTH_F_PAD;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wnum_q, wnum_d, w_cnt_q, w_cnt_d, raddra_q, raddra_d;
  logic [FW-1:0]   pnum_q, pnum_d, p_cnt_q, p_cnt_d;
  logic            busy_q, busy_d;
  logic            inflight_q, inflight_d, infl_last_q, infl_last_d;
  logic [AW-1:0]   infl_addr_q, infl_addr_d;
  logic [DW-1:0]   skid_data_q [2];
  logic [AW-1:0]   skid_addr_q [2];
  logic            skid_last_q [2];
  logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]      cnt_q, cnt_d;

  logic            accept, issue, gate_ok, credit_ok, last_w, last_p, drain_done;
  logic            head_valid, head_last, pop, push, pop_store;
  logic [DW-1:0]   head_data;
  logic [AW-1:0]   head_addr;
  logic [2:0]      occ;

  // Occupancy counts stored entries plus the read whose data arrives next cycle.
  assign occ        = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign credit_ok  = occ < 3'd2;
  assign gate_ok    = load_done_i || (w_cnt_q < wr_addr_i);
  assign last_w     = (w_cnt_q == wnum_q - AW'(1));
  assign last_p     = (p_cnt_q == pnum_q - FW'(1));

  // Empty skid: the arriving pad data bypasses straight to the output head.
  assign head_valid = (cnt_q != 2'd0) || inflight_q;
  assign head_data  = (cnt_q != 2'd0) ? skid_data_q[rd_ptr_q] : weight_rd_data_i;
  assign head_addr  = (cnt_q != 2'd0) ? skid_addr_q[rd_ptr_q] : infl_addr_q;
  assign head_last  = (cnt_q != 2'd0) ? skid_last_q[rd_ptr_q] : infl_last_q;
  assign pop        = head_valid && weight_out_ready_i;
  assign push       = inflight_q && !((cnt_q == 2'd0) && pop);
  assign pop_store  = pop && (cnt_q != 2'd0);
  assign drain_done = (occ == {2'b00, pop});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (read_start_i)
                 state_d = ((weight_num_i == '0) || (pixel_num_i == '0)) ? DRAIN : READ;
      READ:    if (issue && last_w && last_p) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept        = (state_q == IDLE) && read_start_i;
    issue         = (state_q == READ) && credit_ok && gate_ok;
    read_finish_o = (state_q == DONE);
  end

  always_comb begin
    wnum_d      = wnum_q;
    pnum_d      = pnum_q;
    w_cnt_d     = w_cnt_q;
    p_cnt_d     = p_cnt_q;
    raddra_d    = raddra_q;
    busy_d      = busy_q;
    inflight_d  = issue;
    infl_addr_d = infl_addr_q;
    infl_last_d = infl_last_q;
    if (accept) begin
      wnum_d  = weight_num_i;
      pnum_d  = pixel_num_i;
      w_cnt_d = '0;
      p_cnt_d = '0;
      busy_d  = 1'b1;
    end
    if (state_q == DONE) busy_d = 1'b0;
    if (issue) begin
      raddra_d    = w_cnt_q;
      infl_addr_d = w_cnt_q;
      infl_last_d = last_w;
      if (last_w) begin
        w_cnt_d = '0;
        p_cnt_d = p_cnt_q + FW'(1);
      end else begin
        w_cnt_d = w_cnt_q + AW'(1);
      end
    end
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop_store};
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop_store;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wnum_q      <= '0;
      pnum_q      <= '0;
      w_cnt_q     <= '0;
      p_cnt_q     <= '0;
      raddra_q    <= '0;
      busy_q      <= 1'b0;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
      infl_last_q <= 1'b0;
      cnt_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      wnum_q      <= wnum_d;
      pnum_q      <= pnum_d;
      w_cnt_q     <= w_cnt_d;
      p_cnt_q     <= p_cnt_d;
      raddra_q    <= raddra_d;
      busy_q      <= busy_d;
      inflight_q  <= inflight_d;
      infl_addr_q <= infl_addr_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_data_q[0] <= '0;
      skid_data_q[1] <= '0;
      skid_addr_q[0] <= '0;
      skid_addr_q[1] <= '0;
      skid_last_q[0] <= 1'b0;
      skid_last_q[1] <= 1'b0;
    end else if (push) begin
      skid_data_q[wr_ptr_q] <= weight_rd_data_i;
      skid_addr_q[wr_ptr_q] <= infl_addr_q;
      skid_last_q[wr_ptr_q] <= infl_last_q;
    end
  end

  assign raddra_filter_o    = raddra_q;
  assign weight_out_valid_o = head_valid;
  assign weight_out_o       = head_valid ? head_data : '0;
  assign base_address_o     = head_valid ? head_addr : '0;
  assign pixel_done_o       = pop && head_last;
  assign read_busy_o        = busy_q;

endmodule
